mips_pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the MIPS core, replacing the fixed single-delay-slot counter. It holds the fetch address, resolves branch/jump targets, sequences a configurable number of branch delay slots (0–2), and redirects to an exception vector with MIPS-style EPC/branch-delay bookkeeping. It sits between the decode/control unit, which supplies branch requests and operands, and instruction fetch, which consumes `pc`.

---
 rtl/mips_pc_sequencer_if.sv | 28 ++
 rtl/mips_pc_sequencer.sv | 158 +++++++++++++++
 tb/tb_mips_pc_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pc_sequencer_if.sv
// Decode/control-side requests and fetch-side outputs of the MIPS PC sequencer.
// The master drives requests and operands; the slave is the sequencer itself.
interface mips_pc_sequencer_if;
    logic        CntEn;
    logic        is_branch;
    logic [1:0]  PCControl;
    logic [31:0] read_data_1;
    logic [31:0] signed_offset;
    logic [25:0] target;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        in_delay;
    logic [31:0] epc;
    logic        exc_bd;
    logic        addr_fault;
    logic [31:0] badvaddr;

    modport master (
        output CntEn, is_branch, PCControl, read_data_1, signed_offset, target, exc_req,
        input  pc, link_addr, in_delay, epc, exc_bd, addr_fault, badvaddr
    );

    modport slave (
        input  CntEn, is_branch, PCControl, read_data_1, signed_offset, target, exc_req,
        output pc, link_addr, in_delay, epc, exc_bd, addr_fault, badvaddr
    );
endinterface

// File: rtl/mips_pc_sequencer.sv
// MIPS program-counter sequencer: branch target resolution, 0-2 branch delay slots,
// alignment faults and exception redirect with EPC/branch-delay bookkeeping.
module mips_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned DELAY_SLOTS  = 1,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input logic                clk,
    input logic                rst,
    mips_pc_sequencer_if.slave bus
);

    if (DELAY_SLOTS > 2) begin : gen_bad_delay_slots
        $error("mips_pc_sequencer: DELAY_SLOTS must be 0, 1 or 2");
    end

    localparam logic [1:0]  SlotsInit = 2'(DELAY_SLOTS);
    localparam logic [2:0]  SlotsW    = 3'(DELAY_SLOTS);
    localparam logic [31:0] LinkOff   = 32'((DELAY_SLOTS + 1) * 4);

    typedef enum logic [0:0] {StRun, StDelay} state_e;

    state_e      state_q, state_d;
    logic [1:0]  slots_q, slots_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        exc_bd_q, exc_bd_d;
    logic        addr_fault_q, addr_fault_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic        br_valid;
    logic        redir;
    logic [31:0] redir_tgt;
    logic [2:0]  bd_words;
    logic [31:0] bd_back;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_valid = bus.is_branch && (bus.PCControl != 2'b11);
    // Distance back from the current pc to the branch that opened the delay window.
    assign bd_words = SlotsW - {1'b0, slots_q} + 3'd1;
    assign bd_back  = {27'd0, bd_words, 2'b00};

    always_comb begin
        br_tgt = pc_plus4;
        case (bus.PCControl)
            2'b00:   br_tgt = pc_plus4 + (bus.signed_offset << 2);
            2'b01:   br_tgt = {pc_plus4[31:28], bus.target, 2'b00};
            2'b10:   br_tgt = bus.read_data_1;
            default: br_tgt = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            slots_q      <= 2'd0;
            tgt_q        <= 32'd0;
            pc_q         <= RESET_VECTOR;
            epc_q        <= 32'd0;
            exc_bd_q     <= 1'b0;
            addr_fault_q <= 1'b0;
            badvaddr_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            slots_q      <= slots_d;
            tgt_q        <= tgt_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            exc_bd_q     <= exc_bd_d;
            addr_fault_q <= addr_fault_d;
            badvaddr_q   <= badvaddr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slots_d      = slots_q;
        tgt_d        = tgt_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        exc_bd_d     = exc_bd_q;
        badvaddr_d   = badvaddr_q;
        addr_fault_d = 1'b0;
        redir        = 1'b0;
        redir_tgt    = tgt_q;

        if (bus.exc_req) begin
            // Exceptions ignore CntEn and drop any pending or same-cycle branch.
            pc_d    = EXC_VECTOR;
            state_d = StRun;
            slots_d = 2'd0;
            if (state_q == StDelay) begin
                epc_d    = pc_q - bd_back;
                exc_bd_d = 1'b1;
            end else begin
                epc_d    = pc_q;
                exc_bd_d = 1'b0;
            end
        end else if (bus.CntEn) begin
            case (state_q)
                StRun: begin
                    if (br_valid) begin
                        if (DELAY_SLOTS == 0) begin
                            redir     = 1'b1;
                            redir_tgt = br_tgt;
                        end else begin
                            tgt_d   = br_tgt;
                            slots_d = SlotsInit;
                            pc_d    = pc_plus4;
                            state_d = StDelay;
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                StDelay: begin
                    if (slots_q > 2'd1) begin
                        slots_d = slots_q - 2'd1;
                        pc_d    = pc_plus4;
                    end else begin
                        redir     = 1'b1;
                        redir_tgt = tgt_q;
                        slots_d   = 2'd0;
                        state_d   = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end

        if (redir) begin
            if (ALIGN_CHECK && (redir_tgt[1:0] != 2'b00)) begin
                pc_d         = EXC_VECTOR;
                addr_fault_d = 1'b1;
                badvaddr_d   = redir_tgt;
                epc_d        = redir_tgt;
                exc_bd_d     = 1'b0;
            end else begin
                pc_d = redir_tgt;
            end
        end
    end

    always_comb begin
        bus.pc         = pc_q;
        bus.link_addr  = pc_q + LinkOff;
        bus.in_delay   = (state_q == StDelay);
        bus.epc        = epc_q;
        bus.exc_bd     = exc_bd_q;
        bus.addr_fault = addr_fault_q;
        bus.badvaddr   = badvaddr_q;
    end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Randomised scoreboard bench: four sequencer configurations share one stimulus stream
// and are compared every cycle against a behavioural fetch-address model.
module tb_mips_pc_sequencer;

    localparam logic [31:0] ResetVec = 32'hBFC00000;
    localparam logic [31:0] ExcVec   = 32'hBFC00380;
    localparam int          NInst    = 4;
    localparam int          NCycles  = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_en = 1'b0;
    logic        is_branch = 1'b0;
    logic        exc_req = 1'b0;
    logic [1:0]  pc_control = 2'b11;
    logic [31:0] rd1 = 32'd0;
    logic [31:0] soff = 32'd0;
    logic [25:0] jtgt = 26'd0;

    logic [31:0] o_pc [NInst];
    logic [31:0] o_link [NInst];
    logic [31:0] o_epc [NInst];
    logic [31:0] o_bad [NInst];
    logic        o_dly [NInst];
    logic        o_bd [NInst];
    logic        o_flt [NInst];

    always #5 clk = ~clk;

    // Instances: 0,1,2 delay slots with alignment check; 1 delay slot without it.
    for (genvar g = 0; g < NInst; g++) begin : g_dut
        mips_pc_sequencer_if u_if ();
        assign u_if.CntEn         = cnt_en;
        assign u_if.is_branch     = is_branch;
        assign u_if.PCControl     = pc_control;
        assign u_if.read_data_1   = rd1;
        assign u_if.signed_offset = soff;
        assign u_if.target        = jtgt;
        assign u_if.exc_req       = exc_req;
        assign o_pc[g]   = u_if.pc;
        assign o_link[g] = u_if.link_addr;
        assign o_epc[g]  = u_if.epc;
        assign o_bad[g]  = u_if.badvaddr;
        assign o_dly[g]  = u_if.in_delay;
        assign o_bd[g]   = u_if.exc_bd;
        assign o_flt[g]  = u_if.addr_fault;

        mips_pc_sequencer #(
            .RESET_VECTOR (ResetVec),
            .EXC_VECTOR   (ExcVec),
            .DELAY_SLOTS  ((g == 3) ? 1 : g),
            .ALIGN_CHECK  ((g == 3) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] link;
        logic [31:0] epc;
        logic [31:0] bad;
        logic        dly;
        logic        bd;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    // Reference model: fetch address, pending redirect and its origin branch address.
    logic [31:0] m_pc [NInst];
    logic [31:0] m_tgt [NInst];
    logic [31:0] m_brpc [NInst];
    logic [31:0] m_epc [NInst];
    logic [31:0] m_bad [NInst];
    bit          m_pend [NInst];
    bit          m_bd [NInst];
    bit          m_flt [NInst];
    int          m_since [NInst];

    function automatic int ds_of(int i);
        return (i == 3) ? 1 : i;
    endfunction

    function automatic bit al_of(int i);
        return i != 3;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %h, expected %h", name, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NInst; i++) begin
            m_pc[i]    = ResetVec;
            m_tgt[i]   = 32'd0;
            m_brpc[i]  = 32'd0;
            m_epc[i]   = 32'd0;
            m_bad[i]   = 32'd0;
            m_pend[i]  = 1'b0;
            m_bd[i]    = 1'b0;
            m_flt[i]   = 1'b0;
            m_since[i] = 0;
        end
    endtask

    function automatic logic [31:0] branch_target(logic [31:0] p);
        logic [31:0] nxt;
        nxt = p + 32'd4;
        case (pc_control)
            2'b00:   return nxt + soff * 32'd4;
            2'b01:   return {nxt[31:28], jtgt, 2'b00};
            default: return rd1;
        endcase
    endfunction

    task automatic model_redirect(int i, logic [31:0] t);
        if (al_of(i) && (t % 4 != 0)) begin
            m_pc[i]  = ExcVec;
            m_flt[i] = 1'b1;
            m_bad[i] = t;
            m_epc[i] = t;
            m_bd[i]  = 1'b0;
        end else begin
            m_pc[i] = t;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NInst; i++) begin
            m_flt[i] = 1'b0;
            if (exc_req) begin
                m_epc[i]  = m_pend[i] ? m_brpc[i] : m_pc[i];
                m_bd[i]   = m_pend[i];
                m_pend[i] = 1'b0;
                m_pc[i]   = ExcVec;
            end else if (cnt_en) begin
                if (m_pend[i]) begin
                    m_since[i]++;
                    if (m_since[i] == ds_of(i)) begin
                        m_pend[i] = 1'b0;
                        model_redirect(i, m_tgt[i]);
                    end else begin
                        m_pc[i] = m_pc[i] + 32'd4;
                    end
                end else if (is_branch && pc_control != 2'b11) begin
                    if (ds_of(i) == 0) begin
                        model_redirect(i, branch_target(m_pc[i]));
                    end else begin
                        m_tgt[i]   = branch_target(m_pc[i]);
                        m_brpc[i]  = m_pc[i];
                        m_pend[i]  = 1'b1;
                        m_since[i] = 0;
                        m_pc[i]    = m_pc[i] + 32'd4;
                    end
                end else begin
                    m_pc[i] = m_pc[i] + 32'd4;
                end
            end
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < NInst; i++) begin
            sb.push_back('{idx: i, pc: m_pc[i], link: m_pc[i] + 32'((ds_of(i) + 1) * 4),
                           epc: m_epc[i], bad: m_bad[i], dly: m_pend[i], bd: m_bd[i],
                           flt: m_flt[i]});
        end
    endtask

    task automatic randomize_inputs();
        logic [31:0] r;
        int          o;
        cnt_en     = ($urandom_range(0, 7) != 0);
        is_branch  = ($urandom_range(0, 3) == 0);
        pc_control = 2'($urandom_range(0, 3));
        exc_req    = ($urandom_range(0, 39) == 0);
        r = $urandom;
        if ($urandom_range(0, 2) != 0) r[1:0] = 2'b00;
        rd1  = r;
        o    = int'($urandom_range(0, 2047)) - 1024;
        soff = 32'(o);
        jtgt = 26'($urandom);
    endtask

    // Monitor: every edge, compare all expectations issued for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                check("pc", e.idx, o_pc[e.idx], e.pc);
                check("link_addr", e.idx, o_link[e.idx], e.link);
                check("in_delay", e.idx, 32'(o_dly[e.idx]), 32'(e.dly));
                check("epc", e.idx, o_epc[e.idx], e.epc);
                check("exc_bd", e.idx, 32'(o_bd[e.idx]), 32'(e.bd));
                check("addr_fault", e.idx, 32'(o_flt[e.idx]), 32'(e.flt));
                check("badvaddr", e.idx, o_bad[e.idx], e.bad);
            end
        end
    end

    // Stimulus: inputs change on the falling edge, expectations for the next rising edge.
    initial begin
        model_reset();
        repeat (2) begin
            @(negedge clk);
            model_reset();
            push_expected();
        end
        // Straight-line fetch out of reset.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            cnt_en    = 1'b1;
            is_branch = 1'b0;
            exc_req   = 1'b0;
            model_step();
            push_expected();
        end
        for (int c = 0; c < NCycles; c++) begin
            @(negedge clk);
            if (c == 1000 || c == 2000) begin
                // Asynchronous reset mid-cycle, possibly with a branch pending.
                #2 rst = 1'b1;
                #1;
                for (int i = 0; i < NInst; i++) begin
                    check("async_rst_pc", i, o_pc[i], ResetVec);
                    check("async_rst_in_delay", i, 32'(o_dly[i]), 32'd0);
                end
                model_reset();
                push_expected();
            end else begin
                rst = 1'b0;
                randomize_inputs();
                model_step();
                push_expected();
            end
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
